// File: rtl/srlzr_sipo_rx_if.sv
// Bundle for the SIPO deserializer's serial input, output word and handshake.
// master drives the serial stream and iREADY; slave is the deserializer.
interface srlzr_sipo_rx_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  iSRL_IN;
  logic                  iBIT_EN;
  logic                  iSYNC;
  logic                  iREADY;
  logic [DATA_WIDTH-1:0] oDATA;
  logic                  oVALID;
  logic                  oBUSY;
  logic                  oOVERRUN;
  logic                  oPAR_ERR;

  modport master (
    output iSRL_IN, iBIT_EN, iSYNC, iREADY,
    input  oDATA, oVALID, oBUSY, oOVERRUN, oPAR_ERR
  );

  modport slave (
    input  iSRL_IN, iBIT_EN, iSYNC, iREADY,
    output oDATA, oVALID, oBUSY, oOVERRUN, oPAR_ERR
  );
endinterface

// File: rtl/srlzr_sipo_rx.sv
// Serial-in/parallel-out deserializer: LSB-first frames, sync-framed, valid/ready output register.
// Define PARITY_CHECK_EN to expect a trailing parity bit per frame and report oPAR_ERR.
module srlzr_sipo_rx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          PAR_ODD    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  srlzr_sipo_rx_if.slave   bus
);
  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;
  logic                  commit;
  logic [DATA_WIDTH-1:0] word;
`ifdef PARITY_CHECK_EN
  logic                  perr_q, perr_d;
  logic                  word_err;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    commit  = 1'b0;
    word    = sreg_q;
`ifdef PARITY_CHECK_EN
    perr_d   = perr_q;
    word_err = 1'b0;
`endif

    if (valid_q && bus.iREADY) begin
      valid_d = 1'b0;
`ifdef PARITY_CHECK_EN
      perr_d  = 1'b0;
`endif
    end

    if (bus.iBIT_EN) begin
      case (state_q)
        StIdle: begin
          if (bus.iSYNC) begin
            sreg_d    = '0;
            sreg_d[0] = bus.iSRL_IN;
            cnt_d     = CntW'(1);
            state_d   = StShift;
          end
        end
        StShift: begin
          if (bus.iSYNC) begin
            // Resync: the partial word is silently discarded.
            sreg_d    = '0;
            sreg_d[0] = bus.iSRL_IN;
            cnt_d     = CntW'(1);
          end else begin
            for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
              if (cnt_q == CntW'(i)) sreg_d[i] = bus.iSRL_IN;
            end
            if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
              cnt_d   = CntW'(DATA_WIDTH);
              state_d = StParity;
`else
              commit  = 1'b1;
              word    = sreg_d;
              cnt_d   = '0;
              state_d = StIdle;
`endif
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
`ifdef PARITY_CHECK_EN
        StParity: begin
          if (bus.iSYNC) begin
            sreg_d    = '0;
            sreg_d[0] = bus.iSRL_IN;
            cnt_d     = CntW'(1);
            state_d   = StShift;
          end else begin
            commit   = 1'b1;
            word     = sreg_q;
            word_err = bus.iSRL_IN ^ (^sreg_q) ^ PAR_ODD;
            cnt_d    = '0;
            state_d  = StIdle;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end

    // A commit may land in the same cycle the held word is consumed.
    if (commit) begin
      if (!valid_q || bus.iREADY) begin
        data_d  = word;
        valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
        perr_d  = word_err;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sreg_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef PARITY_CHECK_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.oDATA    = data_q;
  assign bus.oVALID   = valid_q;
  assign bus.oBUSY    = (state_q != StIdle);
  assign bus.oOVERRUN = ovr_q;
`ifdef PARITY_CHECK_EN
  assign bus.oPAR_ERR = perr_q;
`else
  assign bus.oPAR_ERR = 1'b0;
`endif
endmodule
